// File: rtl/branch_pkg.sv
// Shared definitions for branch resolution: condition codes and ALU flag bit positions.
// The main control FSM imports this package to drive cond_sel.
package branch_pkg;

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_LT     = 3'd2;
    localparam logic [2:0] COND_GE     = 3'd3;
    localparam logic [2:0] COND_LTU    = 3'd4;
    localparam logic [2:0] COND_GEU    = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_W = 4;

    // The outcome state value is the last_taken output itself.
    typedef enum logic {
        OutNt = 1'b0,
        OutTk = 1'b1
    } outcome_e;

endpackage

// File: rtl/branch_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/branch_ctrl_unit.sv
// Branch resolution and PC-write control: registered ALU flags with same-cycle bypass,
// eight-way condition decode, last-outcome FSM and saturating branch statistics.
module branch_ctrl_unit
    import branch_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned COND_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_load,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              pc_write,
    input  logic              pc_write_cond,
    input  logic [COND_W-1:0] cond_sel,
    input  logic              stat_clr,
    output logic              pc_en,
    output logic              cond_true,
    output logic              last_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_live;
    logic [FLAG_W-1:0] flags_eff;
    logic [2:0]        sel;
    logic              taken;

    outcome_e state_q;
    outcome_e state_d;

    // ---------------------------------------------------------------- flag file
    always_comb begin
        flags_live         = '0;
        flags_live[FLAG_Z] = alu_zero;
        flags_live[FLAG_N] = alu_neg;
        flags_live[FLAG_C] = alu_carry;
        flags_live[FLAG_V] = alu_ovf;
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_load) begin
            flags_d = flags_live;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Bypass lets a compare and its branch share one control state.
    assign flags_eff = flag_load ? flags_live : flags_q;

    // ---------------------------------------------------------------- condition decode
    assign sel = cond_sel[2:0];

    always_comb begin
        cond_true = 1'b0;
        unique case (sel)
            COND_EQ:     cond_true = flags_eff[FLAG_Z];
            COND_NE:     cond_true = ~flags_eff[FLAG_Z];
            COND_LT:     cond_true = flags_eff[FLAG_N] ^ flags_eff[FLAG_V];
            COND_GE:     cond_true = ~(flags_eff[FLAG_N] ^ flags_eff[FLAG_V]);
            COND_LTU:    cond_true = ~flags_eff[FLAG_C];
            COND_GEU:    cond_true = flags_eff[FLAG_C];
            COND_ALWAYS: cond_true = 1'b1;
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

    assign taken = pc_write_cond & cond_true;
    assign pc_en = pc_write | taken;

    // ---------------------------------------------------------------- outcome FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OutNt;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OutNt: if (pc_write_cond && cond_true)  state_d = OutTk;
            OutTk: if (pc_write_cond && !cond_true) state_d = OutNt;
            default: state_d = OutNt;
        endcase
    end

    always_comb begin
        last_taken = 1'b0;
        unique case (state_q)
            OutNt:   last_taken = 1'b0;
            OutTk:   last_taken = 1'b1;
            default: last_taken = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- statistics
    // taken_cnt only ever steps alongside branch_cnt, so it can never overtake it.
    sat_counter #(
        .W (CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (stat_clr),
        .inc   (pc_write_cond),
        .q     (branch_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (stat_clr),
        .inc   (taken),
        .q     (taken_cnt)
    );

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Scoreboard bench for branch_ctrl_unit: driver pushes model expectations, a monitor
// on the falling edge pops and compares them against the DUT.
module tb_branch_ctrl_unit;

    localparam int CNT_W  = 4;
    localparam int COND_W = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              flag_load;
    logic              alu_zero, alu_neg, alu_carry, alu_ovf;
    logic              pc_write, pc_write_cond;
    logic [COND_W-1:0] cond_sel;
    logic              stat_clr;
    logic              pc_en, cond_true, last_taken;
    logic [CNT_W-1:0]  branch_cnt, taken_cnt;

    branch_ctrl_unit #(
        .CNT_W  (CNT_W),
        .COND_W (COND_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flag_load     (flag_load),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .alu_carry     (alu_carry),
        .alu_ovf       (alu_ovf),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond_sel      (cond_sel),
        .stat_clr      (stat_clr),
        .pc_en         (pc_en),
        .cond_true     (cond_true),
        .last_taken    (last_taken),
        .branch_cnt    (branch_cnt),
        .taken_cnt     (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic pc_en;
        logic cond_true;
        logic last_taken;
        int   bcnt;
        int   tcnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: architectural view of the unit.
    logic m_z, m_n, m_c, m_v, m_last;
    int   m_b, m_t;

    function automatic logic cond_eval(int s, logic z, logic n, logic c, logic v);
        case (s)
            0:       return z;
            1:       return !z;
            2:       return n != v;
            3:       return n == v;
            4:       return !c;
            5:       return c;
            6:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_inc(int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    task automatic chk1(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chkn(string name, logic [CNT_W-1:0] act, int req);
        checks++;
        if (act !== req[CNT_W-1:0]) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: apply inputs, push the expectation, advance the model on the edge.
    task automatic step(input logic rst, input logic fl, input logic z, input logic n,
                        input logic c, input logic v, input logic pw, input logic pwc,
                        input int sel, input logic clr);
        logic ez, en, ec, ev, ct;
        exp_t e;
        reset = rst; flag_load = fl;
        alu_zero = z; alu_neg = n; alu_carry = c; alu_ovf = v;
        pc_write = pw; pc_write_cond = pwc; cond_sel = sel[COND_W-1:0]; stat_clr = clr;
        ez = fl ? z : m_z;
        en = fl ? n : m_n;
        ec = fl ? c : m_c;
        ev = fl ? v : m_v;
        ct = cond_eval(sel, ez, en, ec, ev);
        e.pc_en      = pw | (pwc & ct);
        e.cond_true  = ct;
        e.last_taken = m_last;
        e.bcnt       = m_b;
        e.tcnt       = m_t;
        sb.push_back(e);
        @(posedge clk);
        if (rst) begin
            {m_z, m_n, m_c, m_v, m_last} = '0;
            m_b = 0;
            m_t = 0;
        end else begin
            if (fl) {m_z, m_n, m_c, m_v} = {z, n, c, v};
            if (pwc) m_last = ct;
            if (clr) begin
                m_b = 0;
                m_t = 0;
            end else if (pwc) begin
                m_b = sat_inc(m_b);
                if (ct) m_t = sat_inc(m_t);
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    endtask

    task automatic branch(int sel);
        step(0, 0, 0, 0, 0, 0, 0, 1, sel, 0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk1("pc_en", pc_en, mon_e.pc_en);
            chk1("cond_true", cond_true, mon_e.cond_true);
            chk1("last_taken", last_taken, mon_e.last_taken);
            chkn("branch_cnt", branch_cnt, mon_e.bcnt);
            chkn("taken_cnt", taken_cnt, mon_e.tcnt);
        end
    end

    initial begin
        {reset, flag_load, alu_zero, alu_neg, alu_carry, alu_ovf} = '0;
        {pc_write, pc_write_cond, stat_clr} = '0;
        cond_sel = '0;
        // Unchecked preamble reset to bring the DUT out of X.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        {m_z, m_n, m_c, m_v, m_last} = '0;
        m_b = 0;
        m_t = 0;

        // Reset with every input high, then release.
        step(1, 1, 1, 1, 1, 1, 1, 1, 7, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();

        // Compare and EQ branch in the same cycle via bypass.
        step(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        idle();

        // LT taken, then GE not taken.
        step(0, 1, 0, 1, 0, 0, 0, 0, 7, 0);
        branch(2);
        branch(3);
        idle();

        // Unsigned and fixed conditions.
        step(0, 1, 0, 0, 0, 0, 0, 0, 7, 0);
        branch(4);
        branch(5);
        branch(6);
        branch(7);
        step(0, 0, 0, 0, 0, 0, 1, 1, 7, 0);
        idle();

        // Saturation, then clear racing an increment.
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 1);
        repeat (20) branch(6);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 6, 1);
        idle();

        // Reset beats a branch; flags cleared so EQ is false afterwards.
        step(0, 1, 1, 1, 1, 1, 0, 1, 6, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        branch(0);
        idle();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
